// File: rtl/pll_dps_pkg.sv
// Shared types and constants for the PLL dynamic-phase-shift controller.
// Imported by the controller top and its helpers.
package pll_dps_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_WAIT_LO,
    ST_WAIT_HI,
    ST_FIN
  } dps_state_t;

  localparam logic [1:0] DPS_ERR_NONE = 2'd0;
  localparam logic [1:0] DPS_ERR_CNT  = 2'd1;
  localparam logic [1:0] DPS_ERR_TMO  = 2'd2;
  localparam logic [1:0] DPS_ERR_LOCK = 2'd3;

endpackage

// File: rtl/pll_dps_ctrl_sync.sv
// Two-flop synchroniser for single-bit inputs crossing into scanclk.
// Resets to 0 asynchronously.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pll_dps_ctrl.sv
// PLL dynamic-phase-shift controller: issues phase steps one at a time
// and tracks a signed running offset per PLL output counter.
module pll_dps_ctrl
  import pll_dps_pkg::*;
#(
  parameter int NUM_CNT   = 3,
  parameter int STEP_W    = 8,
  parameter int OFS_W     = 16,
  parameter int EN_CYCLES = 2,
  parameter int TIMEOUT   = 1023
) (
  input  logic              scanclk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [4:0]        cmd_cnt,
  input  logic [STEP_W-1:0] cmd_steps,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  input  logic              pll_locked,
  output logic              phase_en,
  output logic              updn,
  output logic [4:0]        cntsel,
  input  logic              phase_done,
  input  logic [4:0]        ofs_sel,
  output logic [OFS_W-1:0]  ofs_q
);

  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam int ENW = $clog2(EN_CYCLES + 1);
  localparam logic [4:0]     NCNT  = 5'(NUM_CNT);
  localparam logic [TW-1:0]  TLAST = TW'(TIMEOUT - 1);
  localparam logic [ENW-1:0] ELAST = ENW'(EN_CYCLES - 1);

  dps_state_t        r_state;
  logic [4:0]        r_cnt;
  logic              r_updn;
  logic [STEP_W-1:0] r_rem;
  logic [ENW-1:0]    r_en_cnt;
  logic [TW-1:0]     r_wait;
  logic              r_done;
  logic              r_err;
  logic [1:0]        r_err_code;
  logic [OFS_W-1:0]  r_ofs [NUM_CNT];

  logic              w_lk_s;
  logic              w_pd_s;
  logic              w_accept;
  logic [STEP_W-1:0] w_abs;

  sync_2ff u_sync_lk (
    .i_clk   (scanclk),
    .i_rst_n (rst_n),
    .i_d     (pll_locked),
    .o_q     (w_lk_s)
  );

  sync_2ff u_sync_pd (
    .i_clk   (scanclk),
    .i_rst_n (rst_n),
    .i_d     (phase_done),
    .o_q     (w_pd_s)
  );

  assign cmd_ready = (r_state == ST_IDLE) & w_lk_s;
  assign w_accept  = cmd_valid & cmd_ready;
  // Two's-complement magnitude: -2^(STEP_W-1) maps to 2^(STEP_W-1).
  assign w_abs     = cmd_steps[STEP_W-1] ? (-cmd_steps) : cmd_steps;

  assign busy     = (r_state != ST_IDLE);
  assign done     = r_done;
  assign err      = r_err;
  assign err_code = r_err_code;
  assign updn     = r_updn;
  assign cntsel   = r_cnt;
  // Gated by the synchronised lock so a lock loss drops it the same cycle.
  assign phase_en = (r_state == ST_PULSE) & w_lk_s;

  always_ff @(posedge scanclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_updn     <= 1'b0;
      r_rem      <= '0;
      r_en_cnt   <= '0;
      r_wait     <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= DPS_ERR_NONE;
      for (int i = 0; i < NUM_CNT; i++) begin
        r_ofs[i] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_cnt      <= cmd_cnt;
            r_updn     <= ~cmd_steps[STEP_W-1];
            r_rem      <= w_abs;
            r_err_code <= DPS_ERR_NONE;
            r_state    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (!w_lk_s) begin
            r_err      <= 1'b1;
            r_err_code <= DPS_ERR_LOCK;
            r_state    <= ST_FIN;
          end else if (r_cnt >= NCNT) begin
            r_err      <= 1'b1;
            r_err_code <= DPS_ERR_CNT;
            r_state    <= ST_FIN;
          end else if (r_rem == '0) begin
            r_done  <= 1'b1;
            r_state <= ST_FIN;
          end else begin
            r_en_cnt <= '0;
            r_state  <= ST_PULSE;
          end
        end
        ST_PULSE: begin
          if (!w_lk_s) begin
            r_err      <= 1'b1;
            r_err_code <= DPS_ERR_LOCK;
            r_state    <= ST_FIN;
          end else if (r_en_cnt == ELAST) begin
            r_wait  <= '0;
            r_state <= ST_WAIT_LO;
          end else begin
            r_en_cnt <= r_en_cnt + ENW'(1);
          end
        end
        ST_WAIT_LO: begin
          if (!w_lk_s) begin
            r_err      <= 1'b1;
            r_err_code <= DPS_ERR_LOCK;
            r_state    <= ST_FIN;
          end else if (!w_pd_s) begin
            r_wait  <= '0;
            r_state <= ST_WAIT_HI;
          end else if (r_wait == TLAST) begin
            r_err      <= 1'b1;
            r_err_code <= DPS_ERR_TMO;
            r_state    <= ST_FIN;
          end else begin
            r_wait <= r_wait + TW'(1);
          end
        end
        ST_WAIT_HI: begin
          if (!w_lk_s) begin
            r_err      <= 1'b1;
            r_err_code <= DPS_ERR_LOCK;
            r_state    <= ST_FIN;
          end else if (w_pd_s) begin
            for (int i = 0; i < NUM_CNT; i++) begin
              if (r_cnt == 5'(i)) begin
                r_ofs[i] <= r_updn ? r_ofs[i] + OFS_W'(1)
                                   : r_ofs[i] - OFS_W'(1);
              end
            end
            r_rem <= r_rem - STEP_W'(1);
            if (r_rem == STEP_W'(1)) begin
              r_done  <= 1'b1;
              r_state <= ST_FIN;
            end else begin
              r_state <= ST_SETUP;
            end
          end else if (r_wait == TLAST) begin
            r_err      <= 1'b1;
            r_err_code <= DPS_ERR_TMO;
            r_state    <= ST_FIN;
          end else begin
            r_wait <= r_wait + TW'(1);
          end
        end
        ST_FIN: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    ofs_q = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (ofs_sel == 5'(i)) begin
        ofs_q = r_ofs[i];
      end
    end
  end

endmodule

// File: tb/tb_pll_dps_ctrl.sv
// Directed bench for pll_dps_ctrl with a simple PLL phase_done model.
// Expected values are hand-derived from the cycle sequence.
module tb_pll_dps_ctrl;

  localparam int NUM_CNT   = 3;
  localparam int STEP_W    = 8;
  localparam int OFS_W     = 16;
  localparam int EN_CYCLES = 2;
  localparam int TIMEOUT   = 1023;

  logic              scanclk;
  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [4:0]        cmd_cnt;
  logic [STEP_W-1:0] cmd_steps;
  logic              busy;
  logic              done;
  logic              err;
  logic [1:0]        err_code;
  logic              pll_locked;
  logic              phase_en;
  logic              updn;
  logic [4:0]        cntsel;
  logic              phase_done = 1'b1;
  logic [4:0]        ofs_sel;
  logic [OFS_W-1:0]  ofs_q;

  int n_assert = 0;
  int n_fail   = 0;

  int   pulses = 0;
  int   en_hi  = 0;
  int   bad    = 0;
  logic prev_en = 1'b0;
  int   m_t = 0;
  logic m_stuck = 1'b0;
  logic       exp_updn = 1'b0;
  logic [4:0] exp_cntsel = 5'd0;

  pll_dps_ctrl #(
    .NUM_CNT   (NUM_CNT),
    .STEP_W    (STEP_W),
    .OFS_W     (OFS_W),
    .EN_CYCLES (EN_CYCLES),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .scanclk    (scanclk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_cnt    (cmd_cnt),
    .cmd_steps  (cmd_steps),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_code   (err_code),
    .pll_locked (pll_locked),
    .phase_en   (phase_en),
    .updn       (updn),
    .cntsel     (cntsel),
    .phase_done (phase_done),
    .ofs_sel    (ofs_sel),
    .ofs_q      (ofs_q)
  );

  initial scanclk = 1'b0;
  always #5 scanclk = ~scanclk;

  // Pulse monitor plus PLL model: phase_done falls 3 cycles after
  // phase_en rises and returns high 4 cycles later.
  always @(negedge scanclk) begin
    if (phase_en) begin
      en_hi = en_hi + 1;
      if (!prev_en) pulses = pulses + 1;
      if (updn !== exp_updn || cntsel !== exp_cntsel) bad = bad + 1;
    end
    if (phase_en && !prev_en) m_t = 1;
    else if (m_t != 0) m_t = m_t + 1;
    if (m_t == 3 && !m_stuck) phase_done = 1'b0;
    if (m_t == 7) begin
      phase_done = 1'b1;
      m_t = 0;
    end
    prev_en = phase_en;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_cmd(input logic [4:0] cnt,
                         input logic [STEP_W-1:0] steps,
                         input int limit, output int k,
                         output logic got_done, output logic got_err);
    @(negedge scanclk);
    cmd_valid = 1'b1;
    cmd_cnt   = cnt;
    cmd_steps = steps;
    @(posedge scanclk);
    #1 cmd_valid = 1'b0;
    k = 0;
    got_done = 1'b0;
    got_err  = 1'b0;
    while (k < limit && !got_done && !got_err) begin
      @(negedge scanclk);
      k++;
      got_done = done;
      got_err  = err;
    end
  endtask

  int   k;
  int   bp, bh, bb;
  logic gd, ge;

  initial begin
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    cmd_valid  = 1'b0;
    cmd_cnt    = '0;
    cmd_steps  = '0;
    ofs_sel    = '0;
    repeat (3) @(negedge scanclk);

    check("rst_phase_en", phase_en, 0);
    check("rst_updn", updn, 0);
    check("rst_cntsel", cntsel, 0);
    check("rst_ready", cmd_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done_err", {done, err}, 0);
    check("rst_err_code", err_code, 0);
    check("rst_ofs", ofs_q, 0);

    rst_n = 1'b1;
    @(negedge scanclk);
    pll_locked = 1'b1;
    @(negedge scanclk);
    check("lk_ready_early", cmd_ready, 0);
    @(negedge scanclk);
    check("lk_ready", cmd_ready, 1);

    // +3 steps on counter 1
    exp_updn = 1'b1; exp_cntsel = 5'd1;
    bp = pulses; bh = en_hi; bb = bad;
    run_cmd(5'd1, 8'd3, 300, k, gd, ge);
    check("p3_done", {gd, ge}, 2'b10);
    check("p3_ready_fin", cmd_ready, 0);
    check("p3_pulses", pulses - bp, 3);
    check("p3_en_width", en_hi - bh, 6);
    check("p3_updn_cntsel", bad - bb, 0);
    check("p3_err_code", err_code, 0);
    ofs_sel = 5'd1;
    @(negedge scanclk);
    check("p3_ofs1", ofs_q, 3);
    check("p3_ready_after", cmd_ready, 1);

    // zero steps: success with no pulse
    bp = pulses;
    run_cmd(5'd1, 8'd0, 20, k, gd, ge);
    check("z_done", {gd, ge}, 2'b10);
    check("z_latency", k, 2);
    check("z_pulses", pulses - bp, 0);
    check("z_ofs1", ofs_q, 3);

    // -128 steps on counter 0
    exp_updn = 1'b0; exp_cntsel = 5'd0;
    bp = pulses; bh = en_hi; bb = bad;
    run_cmd(5'd0, 8'h80, 3000, k, gd, ge);
    check("n128_done", {gd, ge}, 2'b10);
    check("n128_pulses", pulses - bp, 128);
    check("n128_en_width", en_hi - bh, 256);
    check("n128_updn_cntsel", bad - bb, 0);
    ofs_sel = 5'd0;
    #1 check("n128_ofs0", ofs_q, 32'h0000_FF80);
    ofs_sel = 5'd2;
    #1 check("n128_ofs2", ofs_q, 0);
    ofs_sel = 5'd1;
    #1 check("n128_ofs1", ofs_q, 3);
    ofs_sel = 5'd3;
    #1 check("ofs_sel_oob", ofs_q, 0);

    // bad counter
    bp = pulses;
    run_cmd(5'd5, 8'd4, 20, k, gd, ge);
    check("bc_err", {gd, ge}, 2'b01);
    check("bc_latency", k, 2);
    check("bc_code", err_code, 1);
    check("bc_pulses", pulses - bp, 0);
    @(negedge scanclk);
    check("bc_ready", cmd_ready, 1);
    check("bc_code_hold", {err, err_code}, 3'b001);

    // timeout: phase_done never falls
    m_stuck = 1'b1;
    exp_updn = 1'b1; exp_cntsel = 5'd2;
    bp = pulses;
    run_cmd(5'd2, 8'd1, 2000, k, gd, ge);
    check("tmo_err", {gd, ge}, 2'b01);
    check("tmo_latency", k, EN_CYCLES + 2 + TIMEOUT);
    check("tmo_code", err_code, 2);
    check("tmo_phase_en", phase_en, 0);
    check("tmo_pulses", pulses - bp, 1);
    ofs_sel = 5'd2;
    #1 check("tmo_ofs2", ofs_q, 0);
    m_stuck = 1'b0;
    repeat (10) @(negedge scanclk);

    // lock loss during second of four steps
    bp = pulses;
    @(negedge scanclk);
    cmd_valid = 1'b1; cmd_cnt = 5'd2; cmd_steps = 8'd4;
    @(posedge scanclk);
    #1 cmd_valid = 1'b0;
    k = 0;
    while (k < 200 && (pulses - bp) < 2) begin
      @(negedge scanclk);
      #1 k++;
    end
    check("ll_second_pulse", pulses - bp, 2);
    pll_locked = 1'b0;
    k = 0;
    while (k < 10 && phase_en) begin
      @(negedge scanclk);
      k++;
    end
    check("ll_en_drop", (k <= 3), 1);
    k = 0;
    while (k < 20 && !err) begin
      @(negedge scanclk);
      k++;
    end
    check("ll_err", err, 1);
    check("ll_code", err_code, 3);
    check("ll_ofs2", ofs_q, 1);
    cmd_valid = 1'b1; cmd_cnt = 5'd1; cmd_steps = 8'd1;
    repeat (4) @(negedge scanclk);
    cmd_valid = 1'b0;
    check("ll_ready_low", cmd_ready, 0);
    check("ll_ignored", busy, 0);
    pll_locked = 1'b1;
    repeat (3) @(negedge scanclk);
    check("ll_relock", cmd_ready, 1);
    repeat (10) @(negedge scanclk);

    // reset while phase_en is high
    exp_updn = 1'b1; exp_cntsel = 5'd1;
    @(negedge scanclk);
    cmd_valid = 1'b1; cmd_cnt = 5'd1; cmd_steps = 8'd2;
    @(posedge scanclk);
    #1 cmd_valid = 1'b0;
    k = 0;
    while (k < 20 && !phase_en) begin
      @(negedge scanclk);
      k++;
    end
    check("rm_en_high", phase_en, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rm_phase_en", phase_en, 0);
    check("rm_busy", busy, 0);
    check("rm_ready", cmd_ready, 0);
    check("rm_updn_cntsel", {updn, cntsel}, 0);
    check("rm_done_err", {done, err, err_code}, 0);
    ofs_sel = 5'd0;
    #1 check("rm_ofs0", ofs_q, 0);
    ofs_sel = 5'd1;
    #1 check("rm_ofs1", ofs_q, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
